maxpool_2x2: RTL and testbench
==============================

// Module: maxpool_2x2
// PURPOSE
//  Streaming 2x2/stride-2 max-pooling stage after the activation unit of the CNN datapath.
//  Consumes one activation per beat, row-major, for an IMG_W x IMG_H feature map.
//  Emits one pooled maximum per completed 2x2 window, with a pooled-index address and an end-of-map flag.
//  Holds one line buffer of IMG_W/2 partial maxima; no backpressure.
// PARAMETERS
//  DATA_W  8   activation/result width, signed two's complement
//  ADDR_W  10  address width
//  IMG_W   4   map width in pixels (even, >=2)
//  IMG_H   4   map height in pixels (even, >=2)
// PORTS
//  clk                    in   1       clock, all logic on rising edge
//  rst                    in   1       synchronous reset, active-high
//  act_valid_i            in   1       input beat valid
//  act_last_i             in   1       final beat of current map (qualified by act_valid_i)
//  act_result_i           in   DATA_W  activation value (signed)
//  act_result_address_i   in   ADDR_W  source address; informational, not used for positioning
//  pool_result_o          out  DATA_W  pooled maximum
//  pool_result_address_o  out  ADDR_W  pooled element index within map, 0..(IMG_W/2*IMG_H/2-1)
//  pool_last_o            out  1       high with the final pooled output of a map
//  pool_valid_o           out  1       pool_result_o/address/last valid this cycle
// BEHAVIOUR
//  - Reset: all outputs 0; col/row counters, pooled-index counter, line buffer, pair register cleared.
//  - Reset has priority over any input in the same cycle; reset mid-map discards partial windows.
//  - Only beats with act_valid_i=1 advance state; invalid cycles hold all state; outputs pulse one cycle.
//  - Position tracked by internal col (0..IMG_W-1) and row (0..IMG_H-1) counters; col wraps, row increments.
//  - Even col: latch value into pair register. Odd col: pair_max = max(pair_reg, value), signed compare.
//  - Even row, odd col: store pair_max in line_buf[col/2].
//  - Odd row, odd col: window max = max(line_buf[col/2], pair_max); register to pool_result_o,
//    pool_valid_o=1 next cycle (latency 1 clock from completing beat), address = pooled index, then index++.
//  - Ties: either operand (equal values); compare is strict signed (-128 < 127).
//  - pool_last_o=1 on output of window at row IMG_H-1, col IMG_W-1; counters and index return to 0.
//  - act_last_i on the final pixel: same as above (normal end). act_last_i early (any other pixel):
//    beat processed, then counters/index/buffer reset; incomplete windows dropped, no pool_last_o.
//  - Pixels beyond IMG_W*IMG_H without act_last_i: counters wrap, next map starts automatically.
//  - Back-to-back maps with no idle cycle supported; throughput 1 pixel/clock.
// TESTING
//  1. Rst=1 two clocks -> all outputs 0; rst released with valid=0 -> outputs stay 0.
//  2. Map rows {1,2,4,3},{5,6,7,8},{9,10,11,12},{13,14,15,16}, last on 16 -> outputs 6@0, 8@1, 14@2,
//     16@3 with pool_last_o on 16; each valid exactly one clock after rows 1/3 odd-col beats.
//  3. Signed map {1,2,3,4},{-5,-6,-7,-8},{9,10,11,12},{-13,-14,-15,-16} -> 2,4,10,12; last with 12.
//  4. Two maps 1..16 back-to-back -> 6,8,14,16 twice, addresses 0..3 restart, pool_last_o twice.
//  5. Same map with valid deasserted randomly between beats -> identical outputs/addresses, later timing.
//  6. act_last_i on pixel 6 (row1 col1), then fresh 1..16 -> 6@0 only from first map, no pool_last;
//     second map yields 6,8,14,16 addresses 0..3 with pool_last_o.

Source files
------------

// File: rtl/maxpool_2x2_if.sv
// Activation-in / pooled-result-out bundle for the 2x2 max-pooling stage.
// The DUT side is slave; the producer/observer side is master.
interface maxpool_2x2_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic                     act_valid_i;
    logic                     act_last_i;
    logic signed [DATA_W-1:0] act_result_i;
    logic        [ADDR_W-1:0] act_result_address_i;
    logic signed [DATA_W-1:0] pool_result_o;
    logic        [ADDR_W-1:0] pool_result_address_o;
    logic                     pool_last_o;
    logic                     pool_valid_o;

    modport master (
        output act_valid_i, act_last_i, act_result_i, act_result_address_i,
        input  pool_result_o, pool_result_address_o, pool_last_o, pool_valid_o
    );

    modport slave (
        input  act_valid_i, act_last_i, act_result_i, act_result_address_i,
        output pool_result_o, pool_result_address_o, pool_last_o, pool_valid_o
    );
endinterface

// File: rtl/maxpool_2x2.sv
// Streaming 2x2 / stride-2 max pooling over a row-major IMG_W x IMG_H map.
// One line buffer of column-pair maxima; one pooled result per completed window.
module maxpool_2x2 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4
) (
    input  logic          clk,
    input  logic          rst,
    maxpool_2x2_if.slave  bus
);
    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int HW = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;

    function automatic logic signed [DATA_W-1:0] f_max(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    logic        [CW-1:0]     r_col;
    logic        [RW-1:0]     r_row;
    logic        [ADDR_W-1:0] r_idx;
    logic signed [DATA_W-1:0] r_pair;
    logic signed [DATA_W-1:0] r_line_buf [IMG_W/2];

    logic signed [DATA_W-1:0] r_pool_result_p1;
    logic        [ADDR_W-1:0] r_pool_addr_p1;
    logic                     r_pool_last_p1;
    logic                     r_pool_valid_p1;

    logic        [HW-1:0]     w_bidx;
    logic signed [DATA_W-1:0] w_pair_max;
    logic signed [DATA_W-1:0] w_win_max;
    logic                     w_col_end;
    logic                     w_row_end;
    logic                     w_last_px;
    logic                     w_emit;
    logic                     w_early;
    logic                     w_unused;

    assign w_bidx     = HW'(r_col >> 1);
    assign w_pair_max = f_max(r_pair, bus.act_result_i);
    assign w_win_max  = f_max(r_line_buf[w_bidx], w_pair_max);
    assign w_col_end  = (r_col == CW'(IMG_W - 1));
    assign w_row_end  = (r_row == RW'(IMG_H - 1));
    assign w_last_px  = w_col_end && w_row_end;
    assign w_emit     = bus.act_valid_i && r_col[0] && r_row[0];
    // An early last still lets the current beat complete its window before the map restarts.
    assign w_early    = bus.act_valid_i && bus.act_last_i && !w_last_px;
    assign w_unused   = ^bus.act_result_address_i;

    // Stage p1: pooled result registered one clock after the completing beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col            <= '0;
            r_row            <= '0;
            r_idx            <= '0;
            r_pair           <= '0;
            for (int i = 0; i < IMG_W / 2; i++) r_line_buf[i] <= '0;
            r_pool_result_p1 <= '0;
            r_pool_addr_p1   <= '0;
            r_pool_last_p1   <= 1'b0;
            r_pool_valid_p1  <= 1'b0;
        end else begin
            r_pool_valid_p1 <= 1'b0;
            r_pool_last_p1  <= 1'b0;
            if (bus.act_valid_i) begin
                if (!r_col[0]) begin
                    r_pair <= bus.act_result_i;
                end else if (!r_row[0]) begin
                    r_line_buf[w_bidx] <= w_pair_max;
                end

                if (w_emit) begin
                    r_pool_result_p1 <= w_win_max;
                    r_pool_addr_p1   <= r_idx;
                    r_pool_valid_p1  <= 1'b1;
                    r_pool_last_p1   <= w_last_px;
                end

                if (w_early) begin
                    r_col  <= '0;
                    r_row  <= '0;
                    r_idx  <= '0;
                    r_pair <= '0;
                    for (int i = 0; i < IMG_W / 2; i++) r_line_buf[i] <= '0;
                end else begin
                    r_col <= w_col_end ? '0 : r_col + CW'(1);
                    if (w_col_end) r_row <= w_row_end ? '0 : r_row + RW'(1);
                    if (w_emit)    r_idx <= w_last_px ? '0 : r_idx + ADDR_W'(1);
                end
            end
        end
    end

    assign bus.pool_result_o         = r_pool_result_p1;
    assign bus.pool_result_address_o = r_pool_addr_p1;
    assign bus.pool_last_o           = r_pool_last_p1;
    assign bus.pool_valid_o          = r_pool_valid_p1;
endmodule

// File: tb/tb_maxpool_2x2.sv
// Directed bench for maxpool_2x2: captures every pooled output and compares
// it with hand-computed windows, addresses, last flags and latency.
module tb_maxpool_2x2;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    int q_res[$];
    int q_addr[$];
    int q_last[$];
    int q_cyc[$];

    maxpool_2x2_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    maxpool_2x2 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMG_W(4), .IMG_H(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && bus.pool_valid_o) begin
            q_res.push_back(int'($signed(bus.pool_result_o)));
            q_addr.push_back(int'(bus.pool_result_address_o));
            q_last.push_back(int'(bus.pool_last_o));
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.act_valid_i = 1'b0;
        bus.act_last_i  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one beat; returns the cycle count seen just after its consuming edge.
    task automatic beat(input int v, input bit last, output int c);
        bus.act_valid_i  = 1'b1;
        bus.act_last_i   = last;
        bus.act_result_i = DATA_W'(v);
        bus.act_result_address_i = bus.act_result_address_i + 1'b1;
        @(posedge clk);
        #1;
        c = cyc;
        bus.act_valid_i = 1'b0;
        bus.act_last_i  = 1'b0;
    endtask

    task automatic send_map(input int px[16], input int last_at, input bit gaps);
        int c;
        for (int i = 0; i < 16 && i <= last_at; i++) begin
            beat(px[i], (i == last_at), c);
            if (gaps) idle($urandom_range(0, 2));
        end
    endtask

    task automatic clear_q();
        q_res.delete();
        q_addr.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    task automatic expect_outs(input string tag, input int n, input int res[8],
                               input int addr[8], input int last[8]);
        chk({tag, "_count"}, q_res.size(), n);
        for (int i = 0; i < n && i < q_res.size(); i++) begin
            chk($sformatf("%s_res%0d", tag, i), q_res[i], res[i]);
            chk($sformatf("%s_addr%0d", tag, i), q_addr[i], addr[i]);
            chk($sformatf("%s_last%0d", tag, i), q_last[i], last[i]);
        end
    endtask

    int map_a[16]  = '{1, 2, 4, 3, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
    int map_s[16]  = '{1, 2, 3, 4, -5, -6, -7, -8, 9, 10, 11, 12, -13, -14, -15, -16};
    int map_n[16]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
    int map_b[16]  = '{-128, 127, -128, -128, -128, -128, -1, -128,
                       0, -128, -128, -128, -128, -128, -128, -128};

    initial begin
        int c;
        int bc[4];
        bus.act_valid_i = 1'b0;
        bus.act_last_i  = 1'b0;
        bus.act_result_i = '0;
        bus.act_result_address_i = '0;

        // Reset held two clocks, then idle with valid low.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",  int'(bus.pool_valid_o), 0);
        chk("rst_result", int'(bus.pool_result_o), 0);
        chk("rst_addr",   int'(bus.pool_result_address_o), 0);
        chk("rst_last",   int'(bus.pool_last_o), 0);
        rst = 1'b0;
        idle(3);
        chk("idle_valid",  int'(bus.pool_valid_o), 0);
        chk("idle_result", int'(bus.pool_result_o), 0);
        chk("idle_count",  q_res.size(), 0);

        // Basic map with per-window latency check.
        clear_q();
        for (int i = 0; i < 16; i++) begin
            beat(map_a[i], (i == 15), c);
            if (i == 5)  bc[0] = c;
            if (i == 7)  bc[1] = c;
            if (i == 13) bc[2] = c;
            if (i == 15) bc[3] = c;
        end
        idle(3);
        expect_outs("basic", 4, '{6, 8, 14, 16, 0, 0, 0, 0},
                    '{0, 1, 2, 3, 0, 0, 0, 0}, '{0, 0, 0, 1, 0, 0, 0, 0});
        for (int i = 0; i < 4 && i < q_cyc.size(); i++)
            chk($sformatf("basic_lat%0d", i), q_cyc[i], bc[i]);

        // Signed values.
        clear_q();
        send_map(map_s, 15, 1'b0);
        idle(3);
        expect_outs("signed", 4, '{2, 4, 10, 12, 0, 0, 0, 0},
                    '{0, 1, 2, 3, 0, 0, 0, 0}, '{0, 0, 0, 1, 0, 0, 0, 0});

        // Two maps back to back.
        clear_q();
        send_map(map_n, 15, 1'b0);
        send_map(map_n, 15, 1'b0);
        idle(3);
        expect_outs("b2b", 8, '{6, 8, 14, 16, 6, 8, 14, 16},
                    '{0, 1, 2, 3, 0, 1, 2, 3}, '{0, 0, 0, 1, 0, 0, 0, 1});

        // Random idle gaps between beats.
        clear_q();
        send_map(map_n, 15, 1'b1);
        idle(3);
        expect_outs("gaps", 4, '{6, 8, 14, 16, 0, 0, 0, 0},
                    '{0, 1, 2, 3, 0, 0, 0, 0}, '{0, 0, 0, 1, 0, 0, 0, 0});

        // Early last on pixel 6, then a fresh map.
        clear_q();
        send_map(map_n, 5, 1'b0);
        send_map(map_n, 15, 1'b0);
        idle(3);
        expect_outs("early", 5, '{6, 6, 8, 14, 16, 0, 0, 0},
                    '{0, 0, 1, 2, 3, 0, 0, 0}, '{0, 0, 0, 0, 1, 0, 0, 0});

        // Extreme signed values.
        clear_q();
        send_map(map_b, 15, 1'b0);
        idle(3);
        expect_outs("extreme", 4, '{127, -1, 0, -128, 0, 0, 0, 0},
                    '{0, 1, 2, 3, 0, 0, 0, 0}, '{0, 0, 0, 1, 0, 0, 0, 0});

        // Reset mid-map discards the partial windows.
        clear_q();
        send_map(map_n, 15, 1'b0);
        for (int i = 0; i < 6; i++) beat(100, 1'b0, c);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_valid", int'(bus.pool_valid_o), 0);
        clear_q();
        send_map(map_a, 15, 1'b0);
        idle(3);
        expect_outs("midrst", 4, '{6, 8, 14, 16, 0, 0, 0, 0},
                    '{0, 1, 2, 3, 0, 0, 0, 0}, '{0, 0, 0, 1, 0, 0, 0, 0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
